// File: rtl/rgb_frame_stream_gen.sv
// rgb_frame_stream_gen
// Synthetic RGB video source. It drives one FRAME_WIDTH x FRAME_HEIGHT raster
// as a 24-bit AXI4-Stream. The stream uses SOF on tuser and EOL on tlast, and
// LINE_GAP idle cycles follow each line except the last one.
// Ports:
//   mmclk, reset              stream clock (rising edge) / async active-low reset
//   start                     level; begins a frame when sampled in IDLE
//   continuous                sampled at end of frame; 1 = run the next frame
//   pattern_sel, solid_rgb    pattern config (0/3 solid, 1 ramp, 2 colour bars)
//   m_axis_mm2s_*             AXI4-Stream master (tready in; tvalid/tdata/tuser/tlast out)
//   x_coord, y_coord          coordinates of the pixel currently presented
//   busy, frame_done          not-IDLE flag / one-cycle end-of-frame pulse
//   frame_count               completed frames, wraps at 16 bits
module rgb_frame_stream_gen #(
  parameter int FRAME_WIDTH  = 400,
  parameter int FRAME_HEIGHT = 300,
  parameter int LINE_GAP     = 4
) (
  input  logic        mmclk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  input  logic        m_axis_mm2s_tready,
  output logic        m_axis_mm2s_tvalid,
  output logic [23:0] m_axis_mm2s_tdata,
  output logic        m_axis_mm2s_tuser,
  output logic        m_axis_mm2s_tlast,
  output logic [11:0] x_coord,
  output logic [11:0] y_coord,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP, ST_DONE} state_t;

  localparam logic [11:0] X_LAST   = 12'(FRAME_WIDTH - 1);
  localparam logic [11:0] Y_LAST   = 12'(FRAME_HEIGHT - 1);
  localparam logic [11:0] BAR_LAST = 12'((FRAME_WIDTH / 8) - 1);
  localparam logic [15:0] GAP_LOAD = (LINE_GAP > 0) ? 16'(LINE_GAP - 1) : 16'd0;

  // Colour-bar palette lookup
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [11:0] x_r, x_s, y_r, y_s;
  logic [11:0] bar_px_r, bar_px_s;
  logic [2:0]  bar_idx_r, bar_idx_s;
  logic [15:0] gap_r, gap_s;
  logic [1:0]  pat_r, pat_s;
  logic [23:0] rgb_r, rgb_s;
  logic [15:0] fcnt_r, fcnt_s;
  logic        done_s, xfer_s;
  logic [23:0] pix_s;
  logic        tvalid_r, tuser_r, tlast_r, busy_r, done_r;
  logic [23:0] tdata_r;

  // Next-state, coordinate, bar-counter and config-latch logic
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    bar_px_s  = bar_px_r;
    bar_idx_s = bar_idx_r;
    gap_s     = gap_r;
    pat_s     = pat_r;
    rgb_s     = rgb_r;
    fcnt_s    = fcnt_r;
    done_s    = 1'b0;
    xfer_s    = tvalid_r & m_axis_mm2s_tready;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_ACTIVE;
          x_s       = 12'd0;
          y_s       = 12'd0;
          bar_px_s  = 12'd0;
          bar_idx_s = 3'd0;
          pat_s     = pattern_sel;
          rgb_s     = solid_rgb;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (xfer_s) begin
          if (x_r != X_LAST) begin
            x_s = x_r + 12'd1;
            // Bar index advances every BAR_W pixels and holds at the last bar
            if (bar_px_r == BAR_LAST) begin
              bar_px_s = 12'd0;
              if (bar_idx_r != 3'd7) begin
                bar_idx_s = bar_idx_r + 3'd1;
              end else begin
                bar_idx_s = bar_idx_r;
              end
            end else begin
              bar_px_s = bar_px_r + 12'd1;
            end
          end else begin
            x_s       = 12'd0;
            bar_px_s  = 12'd0;
            bar_idx_s = 3'd0;
            if (y_r == Y_LAST) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              fcnt_s  = fcnt_r + 16'd1;
            end else begin
              y_s = y_r + 12'd1;
              if (LINE_GAP > 0) begin
                state_s = ST_GAP;
                gap_s   = GAP_LOAD;
              end else begin
                state_s = ST_ACTIVE;
              end
            end
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_GAP: begin
        if (gap_r == 16'd0) begin
          state_s = ST_ACTIVE;
        end else begin
          gap_s = gap_r - 16'd1;
        end
      end
      ST_DONE: begin
        x_s       = 12'd0;
        y_s       = 12'd0;
        bar_px_s  = 12'd0;
        bar_idx_s = 3'd0;
        if (continuous) begin
          pat_s = pattern_sel;
          rgb_s = solid_rgb;
          if (LINE_GAP > 0) begin
            state_s = ST_GAP;
            gap_s   = GAP_LOAD;
          end else begin
            state_s = ST_ACTIVE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Pixel value for the coordinates about to be presented
  always_comb begin
    pix_s = rgb_s;
    case (pat_s)
      2'd1:    pix_s = {x_s[7:0], y_s[7:0], x_s[7:0] + y_s[7:0]};
      2'd2:    pix_s = bar_colour(bar_idx_s);
      default: pix_s = rgb_s;
    endcase
  end

  // State, counters, latched config and registered stream outputs
  always_ff @(posedge mmclk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      x_r       <= 12'd0;
      y_r       <= 12'd0;
      bar_px_r  <= 12'd0;
      bar_idx_r <= 3'd0;
      gap_r     <= 16'd0;
      pat_r     <= 2'd0;
      rgb_r     <= 24'd0;
      fcnt_r    <= 16'd0;
      done_r    <= 1'b0;
      tvalid_r  <= 1'b0;
      tuser_r   <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= 24'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      bar_px_r  <= bar_px_s;
      bar_idx_r <= bar_idx_s;
      gap_r     <= gap_s;
      pat_r     <= pat_s;
      rgb_r     <= rgb_s;
      fcnt_r    <= fcnt_s;
      done_r    <= done_s;
      tvalid_r  <= (state_s == ST_ACTIVE);
      tuser_r   <= (state_s == ST_ACTIVE) && (x_s == 12'd0) && (y_s == 12'd0);
      tlast_r   <= (state_s == ST_ACTIVE) && (x_s == X_LAST);
      tdata_r   <= pix_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign m_axis_mm2s_tvalid = tvalid_r;
  assign m_axis_mm2s_tdata  = tdata_r;
  assign m_axis_mm2s_tuser  = tuser_r;
  assign m_axis_mm2s_tlast  = tlast_r;
  assign x_coord            = x_r;
  assign y_coord            = y_r;
  assign busy               = busy_r;
  assign frame_done         = done_r;
  assign frame_count        = fcnt_r;

endmodule

// File: tb/tb_rgb_frame_stream_gen.sv
// Directed bench for rgb_frame_stream_gen. It uses three instances with
// different geometries: A 400x2 gap 4, B 16x2 gap 4 and C 8x2 gap 0.
module tb_rgb_frame_stream_gen;

  logic              mmclk;
  logic              reset;
  logic [2:0]        start_s;
  logic              continuous;
  logic [1:0]        pattern_sel;
  logic [23:0]       solid_rgb;
  logic              tready;
  logic [2:0]        tvalid_s, tuser_s, tlast_s, busy_s, done_s;
  logic [2:0][23:0]  tdata_s;
  logic [2:0][11:0]  x_s, y_s;
  logic [2:0][15:0]  fcnt_s;

  int check_cnt = 0;
  int err_cnt   = 0;

  int beats, bad, gap_bad, dgap_bad, stall_bad, pulses, tuser_cnt, tlast_cnt;
  logic [23:0] beat_data [0:1023];

  rgb_frame_stream_gen #(.FRAME_WIDTH(400), .FRAME_HEIGHT(2), .LINE_GAP(4)) u_dut_a (
    .mmclk(mmclk), .reset(reset), .start(start_s[0]), .continuous(continuous),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .m_axis_mm2s_tready(tready),
    .m_axis_mm2s_tvalid(tvalid_s[0]), .m_axis_mm2s_tdata(tdata_s[0]),
    .m_axis_mm2s_tuser(tuser_s[0]), .m_axis_mm2s_tlast(tlast_s[0]),
    .x_coord(x_s[0]), .y_coord(y_s[0]), .busy(busy_s[0]),
    .frame_done(done_s[0]), .frame_count(fcnt_s[0]));

  rgb_frame_stream_gen #(.FRAME_WIDTH(16), .FRAME_HEIGHT(2), .LINE_GAP(4)) u_dut_b (
    .mmclk(mmclk), .reset(reset), .start(start_s[1]), .continuous(continuous),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .m_axis_mm2s_tready(tready),
    .m_axis_mm2s_tvalid(tvalid_s[1]), .m_axis_mm2s_tdata(tdata_s[1]),
    .m_axis_mm2s_tuser(tuser_s[1]), .m_axis_mm2s_tlast(tlast_s[1]),
    .x_coord(x_s[1]), .y_coord(y_s[1]), .busy(busy_s[1]),
    .frame_done(done_s[1]), .frame_count(fcnt_s[1]));

  rgb_frame_stream_gen #(.FRAME_WIDTH(8), .FRAME_HEIGHT(2), .LINE_GAP(0)) u_dut_c (
    .mmclk(mmclk), .reset(reset), .start(start_s[2]), .continuous(continuous),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .m_axis_mm2s_tready(tready),
    .m_axis_mm2s_tvalid(tvalid_s[2]), .m_axis_mm2s_tdata(tdata_s[2]),
    .m_axis_mm2s_tuser(tuser_s[2]), .m_axis_mm2s_tlast(tlast_s[2]),
    .x_coord(x_s[2]), .y_coord(y_s[2]), .busy(busy_s[2]),
    .frame_done(done_s[2]), .frame_count(fcnt_s[2]));

  // Free-running stream clock
  initial begin
    mmclk = 1'b0;
    forever #5 mmclk = ~mmclk;
  end

  // Single comparison point: counts and reports
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference pixel for coordinate (ex, ey)
  function automatic logic [23:0] model_px(input int pat, input int ex, input int ey,
                                           input int w, input logic [23:0] sol);
    logic [7:0] r, g, b;
    r = 8'(ex);
    g = 8'(ey);
    b = 8'(ex + ey);
    case (pat)
      1: return {r, g, b};
      2: begin
        case (ex / (w / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      default: return sol;
    endcase
  endfunction

  // Observe instance d for nframes frames, recounting x/y and checking each beat
  task automatic collect(input int d, input int w, input int h, input int gap,
                         input bit rnd, input int max_cyc, input int nframes);
    int ex, ey, run, cyc;
    bit stalled, prev_final;
    logic [23:0] pd;
    logic pl, pu;
    logic [11:0] px, py;
    beats = 0; bad = 0; gap_bad = 0; dgap_bad = 0; stall_bad = 0;
    pulses = 0; tuser_cnt = 0; tlast_cnt = 0;
    ex = 0; ey = 0; run = 0; cyc = 0; stalled = 1'b0; prev_final = 1'b0;
    pd = 24'd0; pl = 1'b0; pu = 1'b0; px = 12'd0; py = 12'd0;
    while (pulses < nframes && cyc < max_cyc) begin
      @(posedge mmclk); #1;
      cyc++;
      start_s = 3'b000;
      if (stalled && (!tvalid_s[d] || tdata_s[d] != pd || tlast_s[d] != pl ||
                      tuser_s[d] != pu || x_s[d] != px || y_s[d] != py))
        stall_bad++;
      if (done_s[d] != prev_final) dgap_bad++;
      prev_final = 1'b0;
      if (done_s[d]) pulses++;
      if (nframes > 1 && pulses == nframes - 1 && !done_s[d]) continuous = 1'b0;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid_s[d]) begin
        if (tready) begin
          if (x_s[d] != 12'(ex) || y_s[d] != 12'(ey) ||
              tuser_s[d] != (ex == 0 && ey == 0) || tlast_s[d] != (ex == w - 1) ||
              tdata_s[d] != model_px(int'(pattern_sel), ex, ey, w, solid_rgb))
            bad++;
          if (ex == 0 && ey > 0 && run != gap) gap_bad++;
          beat_data[ey * w + ex] = tdata_s[d];
          beats++;
          if (tuser_s[d]) tuser_cnt++;
          if (tlast_s[d]) tlast_cnt++;
          if (ex == w - 1 && ey == h - 1) prev_final = 1'b1;
          ex++;
          if (ex == w) begin
            ex = 0;
            ey++;
            if (ey == h) ey = 0;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = tdata_s[d]; pl = tlast_s[d]; pu = tuser_s[d]; px = x_s[d]; py = y_s[d];
        end
        run = 0;
      end else begin
        run++;
        stalled = 1'b0;
      end
    end
    tready = 1'b1;
  endtask

  initial begin
    bit found;
    reset = 1'b0; start_s = 3'b000; continuous = 1'b0; pattern_sel = 2'd0;
    solid_rgb = 24'd0; tready = 1'b1;
    #23;
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("rst_tvalid%0d", d), 32'(tvalid_s[d]), 32'd0);
      check_val($sformatf("rst_busy%0d", d), 32'(busy_s[d]), 32'd0);
      check_val($sformatf("rst_fcnt%0d", d), 32'(fcnt_s[d]), 32'd0);
      check_val($sformatf("rst_tdata%0d", d), 32'(tdata_s[d]), 32'd0);
    end
    @(negedge mmclk); reset = 1'b1;

    // Ramp on 400x2, full-rate
    pattern_sel = 2'd1;
    @(posedge mmclk); #1; start_s[0] = 1'b1;
    collect(0, 400, 2, 4, 1'b0, 3000, 1);
    check_val("a_frames", 32'(pulses), 32'd1);
    check_val("a_beats", 32'(beats), 32'd800);
    check_val("a_model", 32'(bad), 32'd0);
    check_val("a_gap", 32'(gap_bad), 32'd0);
    check_val("a_done_gap", 32'(dgap_bad), 32'd0);
    check_val("a_tuser_cnt", 32'(tuser_cnt), 32'd1);
    check_val("a_tlast_cnt", 32'(tlast_cnt), 32'd2);
    check_val("a_first", 32'(beat_data[0]), 32'h000000);
    check_val("a_eol0", 32'(beat_data[399]), 32'h8F008F);
    check_val("a_last", 32'(beat_data[799]), 32'h8F0190);
    check_val("a_fcnt", 32'(fcnt_s[0]), 32'd1);
    @(posedge mmclk); #1;
    check_val("a_idle_tvalid", 32'(tvalid_s[0]), 32'd0);
    check_val("a_idle_busy", 32'(busy_s[0]), 32'd0);
    check_val("a_done_pulse", 32'(done_s[0]), 32'd0);

    // Ramp on 16x2 with a 4-cycle line gap
    @(posedge mmclk); #1; start_s[1] = 1'b1;
    collect(1, 16, 2, 4, 1'b0, 500, 1);
    check_val("b_frames", 32'(pulses), 32'd1);
    check_val("b_beats", 32'(beats), 32'd32);
    check_val("b_gap", 32'(gap_bad), 32'd0);
    check_val("b_done_gap", 32'(dgap_bad), 32'd0);
    check_val("b_model", 32'(bad), 32'd0);
    check_val("b_fcnt", 32'(fcnt_s[1]), 32'd1);

    // Colour bars on 16x2 under random backpressure
    pattern_sel = 2'd2;
    @(posedge mmclk); #1; start_s[1] = 1'b1;
    collect(1, 16, 2, 4, 1'b1, 1000, 1);
    check_val("bar_frames", 32'(pulses), 32'd1);
    check_val("bar_beats", 32'(beats), 32'd32);
    check_val("bar_model", 32'(bad), 32'd0);
    check_val("bar_stall", 32'(stall_bad), 32'd0);
    check_val("bar_x0", 32'(beat_data[0]), 32'hFFFFFF);
    check_val("bar_x1", 32'(beat_data[1]), 32'hFFFFFF);
    check_val("bar_x2", 32'(beat_data[2]), 32'hFFFF00);
    check_val("bar_x14", 32'(beat_data[14]), 32'h000000);
    check_val("bar_x15", 32'(beat_data[15]), 32'h000000);
    check_val("bar_y1x0", 32'(beat_data[16]), 32'hFFFFFF);
    check_val("bar_fcnt", 32'(fcnt_s[1]), 32'd2);

    // Continuous solid frames on 8x2, gap 0
    pattern_sel = 2'd0; solid_rgb = 24'h123456; continuous = 1'b1;
    @(posedge mmclk); #1; start_s[2] = 1'b1;
    collect(2, 8, 2, 0, 1'b0, 500, 3);
    check_val("cont_frames", 32'(pulses), 32'd3);
    check_val("cont_beats", 32'(beats), 32'd48);
    check_val("cont_tuser", 32'(tuser_cnt), 32'd3);
    check_val("cont_model", 32'(bad), 32'd0);
    check_val("cont_data", 32'(beat_data[0]), 32'h123456);
    check_val("cont_fcnt", 32'(fcnt_s[2]), 32'd3);
    @(posedge mmclk); #1;
    check_val("cont_idle_busy", 32'(busy_s[2]), 32'd0);
    check_val("cont_idle_tvalid", 32'(tvalid_s[2]), 32'd0);

    // Back-to-back lines with no gap
    pattern_sel = 2'd1; continuous = 1'b0;
    @(posedge mmclk); #1; start_s[2] = 1'b1;
    collect(2, 8, 2, 0, 1'b0, 200, 1);
    check_val("ng_beats", 32'(beats), 32'd16);
    check_val("ng_tlast", 32'(tlast_cnt), 32'd2);
    check_val("ng_gap", 32'(gap_bad), 32'd0);
    check_val("ng_model", 32'(bad), 32'd0);
    check_val("ng_b8", 32'(beat_data[7]), 32'h070007);
    check_val("ng_b16", 32'(beat_data[15]), 32'h070108);
    check_val("ng_fcnt", 32'(fcnt_s[2]), 32'd4);

    // Async reset in the middle of a frame, then restart
    @(posedge mmclk); #1; start_s[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge mmclk); #1;
      start_s = 3'b000;
      if (tvalid_s[1] && x_s[1] == 12'd5 && y_s[1] == 12'd1) found = 1'b1;
    end
    check_val("rst_reach", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("mid_rst_tvalid", 32'(tvalid_s[1]), 32'd0);
    check_val("mid_rst_busy", 32'(busy_s[1]), 32'd0);
    check_val("mid_rst_fcnt", 32'(fcnt_s[1]), 32'd0);
    #1 reset = 1'b1;
    @(posedge mmclk); #1; start_s[1] = 1'b1;
    @(posedge mmclk); #1; start_s = 3'b000;
    check_val("restart_tvalid", 32'(tvalid_s[1]), 32'd1);
    check_val("restart_tuser", 32'(tuser_s[1]), 32'd1);
    check_val("restart_x", 32'(x_s[1]), 32'd0);
    check_val("restart_y", 32'(y_s[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
